// File: rtl/cache_bus_arbiter_pkg.sv
// rtl/cache_bus_arbiter_pkg.sv - shared encodings and defaults for the cache bus arbiter
package cache_bus_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE = 2'd0;
  localparam logic [1:0] ARB_ADDR = 2'd1;
  localparam logic [1:0] ARB_DATA = 2'd2;

  localparam logic ARB_OWN_IC = 1'b0;
  localparam logic ARB_OWN_DC = 1'b1;

  localparam int ARB_BEATS_DEF      = 4;
  localparam int ARB_STARVE_MAX_DEF = 3;

endpackage

// File: rtl/arb_prio_starve.sv
// rtl/arb_prio_starve.sv - dcache-first priority pick with a saturating icache starve counter
module arb_prio_starve
  import cache_bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ic_req,
  input  logic dc_req,
  input  logic arb_en,
  output logic grant_valid,
  output logic grant_dc
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_q;
  logic             starved;

  assign starved     = (starve_q == CNT_W'(STARVE_MAX));
  assign grant_valid = arb_en && (ic_req || dc_req);
  assign grant_dc    = dc_req && !(ic_req && starved);

  // The count only moves on an actual grant, so a burst in flight never changes priority.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_q <= '0;
    end else if (grant_valid) begin
      if (grant_dc && ic_req) begin
        if (!starved) begin
          starve_q <= starve_q + CNT_W'(1);
        end
      end else begin
        starve_q <= '0;
      end
    end
  end

endmodule

// File: rtl/cache_bus_arbiter.sv
// rtl/cache_bus_arbiter.sv - shares one burst memory port between icache refills and dcache refill/writeback
module cache_bus_arbiter
  import cache_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int BEATS      = ARB_BEATS_DEF,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     ic_req_i,
  input  logic [ADDR_W-1:0]        ic_addr_i,
  output logic                     ic_rvalid_o,
  output logic                     ic_done_o,
  input  logic                     dc_req_i,
  input  logic                     dc_we_i,
  input  logic [ADDR_W-1:0]        dc_addr_i,
  input  logic [DATA_W-1:0]        dc_wdata_i,
  output logic [$clog2(BEATS)-1:0] dc_beat_o,
  output logic                     dc_rvalid_o,
  output logic                     dc_done_o,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ADDR_W-1:0]        mem_addr_o,
  input  logic                     mem_gnt_i,
  output logic [DATA_W-1:0]        mem_wdata_o,
  input  logic                     mem_beat_i,
  input  logic [DATA_W-1:0]        mem_rdata_i
);

  localparam int BEAT_W = $clog2(BEATS);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  logic [1:0]        state_q;
  logic              owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [BEAT_W-1:0] beat_q;

  logic arb_en;
  logic grant_valid;
  logic grant_dc;
  logic data_beat;
  logic last_beat;

  assign arb_en = (state_q == ARB_IDLE);

  arb_prio_starve #(
    .STARVE_MAX (STARVE_MAX)
  ) u_prio (
    .clk         (clk),
    .rst         (rst),
    .ic_req      (ic_req_i),
    .dc_req      (dc_req_i),
    .arb_en      (arb_en),
    .grant_valid (grant_valid),
    .grant_dc    (grant_dc)
  );

  // Beats outside DATA are ignored entirely; that keeps stray memory strobes from skewing the count.
  assign data_beat = (state_q == ARB_DATA) && mem_beat_i;
  assign last_beat = data_beat && (beat_q == LAST_BEAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= ARB_OWN_IC;
      we_q    <= 1'b0;
      addr_q  <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          if (grant_valid) begin
            owner_q <= grant_dc ? ARB_OWN_DC : ARB_OWN_IC;
            addr_q  <= grant_dc ? dc_addr_i : ic_addr_i;
            we_q    <= grant_dc && dc_we_i;
            state_q <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          if (mem_gnt_i) begin
            beat_q  <= '0;
            state_q <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (last_beat) begin
            beat_q  <= '0;
            state_q <= ARB_IDLE;
          end else if (data_beat) begin
            beat_q <= beat_q + BEAT_W'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_req_o   = (state_q == ARB_ADDR);
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = dc_wdata_i;
  assign rdata_o     = mem_rdata_i;

  assign ic_rvalid_o = data_beat && !we_q && (owner_q == ARB_OWN_IC);
  assign dc_rvalid_o = data_beat && !we_q && (owner_q == ARB_OWN_DC);
  assign ic_done_o   = last_beat && (owner_q == ARB_OWN_IC);
  assign dc_done_o   = last_beat && (owner_q == ARB_OWN_DC);
  assign dc_beat_o   = (owner_q == ARB_OWN_DC) ? beat_q : '0;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// tb/tb_cache_bus_arbiter.sv - self-checking bench for cache_bus_arbiter
module tb_cache_bus_arbiter;

  localparam int BEATS = 4;

  logic        clk;
  logic        rst;
  logic        ic_req_i;
  logic [63:0] ic_addr_i;
  logic        ic_rvalid_o;
  logic        ic_done_o;
  logic        dc_req_i;
  logic        dc_we_i;
  logic [63:0] dc_addr_i;
  logic [63:0] dc_wdata_i;
  logic [1:0]  dc_beat_o;
  logic        dc_rvalid_o;
  logic        dc_done_o;
  logic [63:0] rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [63:0] mem_addr_o;
  logic        mem_gnt_i;
  logic [63:0] mem_wdata_o;
  logic        mem_beat_i;
  logic [63:0] mem_rdata_i;

  cache_bus_arbiter #(
    .ADDR_W (64), .DATA_W (64), .BEATS (BEATS), .STARVE_MAX (3)
  ) dut (
    .clk (clk), .rst (rst),
    .ic_req_i (ic_req_i), .ic_addr_i (ic_addr_i), .ic_rvalid_o (ic_rvalid_o), .ic_done_o (ic_done_o),
    .dc_req_i (dc_req_i), .dc_we_i (dc_we_i), .dc_addr_i (dc_addr_i), .dc_wdata_i (dc_wdata_i),
    .dc_beat_o (dc_beat_o), .dc_rvalid_o (dc_rvalid_o), .dc_done_o (dc_done_o), .rdata_o (rdata_o),
    .mem_req_o (mem_req_o), .mem_we_o (mem_we_o), .mem_addr_o (mem_addr_o), .mem_gnt_i (mem_gnt_i),
    .mem_wdata_o (mem_wdata_o), .mem_beat_i (mem_beat_i), .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          ic_req;
    bit          dc_req;
    bit          dc_we;
    logic [63:0] ic_addr;
    logic [63:0] dc_addr;
    bit          exp_dc;
    int          gnt_dly;
    bit          gap;
    bit          pre_beat;
    logic [63:0] dbase;
  } vec_t;

  typedef struct packed {
    logic        dc;
    logic [63:0] data;
  } sb_t;

  int   errors = 0;
  int   checks = 0;
  sb_t  sb[$];
  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic sb_check();
    sb_t e;
    if (ic_rvalid_o || dc_rvalid_o) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("sb_owner", dc_rvalid_o, e.dc);
        chk("sb_rdata", rdata_o, e.data);
      end
    end
  endtask

  task automatic chk_all_zero();
    chk("zero_mem_req", mem_req_o, 0);
    chk("zero_ic_rvalid", ic_rvalid_o, 0);
    chk("zero_dc_rvalid", dc_rvalid_o, 0);
    chk("zero_ic_done", ic_done_o, 0);
    chk("zero_dc_done", dc_done_o, 0);
    chk("zero_dc_beat", dc_beat_o, 0);
    chk("zero_mem_addr", mem_addr_o, 0);
    chk("zero_mem_we", mem_we_o, 0);
  endtask

  task automatic wait_req(input bit stray_beat, input int exp_polls);
    int polls;
    polls = 0;
    do begin
      @(negedge clk);
      mem_gnt_i  = 1'b0;
      mem_beat_i = stray_beat;
      #1;
      polls++;
      chk("rvalid_idle", ic_rvalid_o | dc_rvalid_o, 0);
    end while (!mem_req_o && polls < 20);
    chk("arb_latency", 64'(polls), 64'(exp_polls));
  endtask

  task automatic run_burst(input vec_t v, input int exp_polls);
    int          b;
    int          cyc;
    bit          beat;
    bit          exp_we;
    logic [63:0] exp_addr;
    exp_we   = v.exp_dc & v.dc_we;
    exp_addr = v.exp_dc ? v.dc_addr : v.ic_addr;
    wait_req(v.pre_beat, exp_polls);
    chk("mem_addr", mem_addr_o, exp_addr);
    chk("mem_we", mem_we_o, exp_we);
    for (int i = 0; i < v.gnt_dly; i++) begin
      @(negedge clk);
      #1;
      chk("req_hold", mem_req_o, 1);
      chk("addr_hold", mem_addr_o, exp_addr);
      chk("rvalid_addr", ic_rvalid_o | dc_rvalid_o, 0);
    end
    @(negedge clk);
    mem_gnt_i = 1'b1;
    #1;
    chk("req_at_gnt", mem_req_o, 1);
    b   = 0;
    cyc = 0;
    while (b < BEATS && cyc < 40) begin
      @(negedge clk);
      mem_gnt_i   = 1'b0;
      beat        = !(v.gap && cyc[0]);
      mem_beat_i  = beat;
      mem_rdata_i = v.dbase + 64'(b);
      dc_wdata_i  = 64'hD000 + 64'(b);
      if (beat && !exp_we) sb.push_back('{v.exp_dc, v.dbase + 64'(b)});
      #1;
      chk("req_in_data", mem_req_o, 0);
      chk("ic_rvalid", ic_rvalid_o, beat && !exp_we && !v.exp_dc);
      chk("dc_rvalid", dc_rvalid_o, beat && !exp_we && v.exp_dc);
      sb_check();
      chk("dc_beat", dc_beat_o, v.exp_dc ? 64'(b) : 64'd0);
      if (exp_we) chk("mem_wdata", mem_wdata_o, 64'hD000 + 64'(b));
      chk("ic_done", ic_done_o, beat && b == BEATS - 1 && !v.exp_dc);
      chk("dc_done", dc_done_o, beat && b == BEATS - 1 && v.exp_dc);
      if (beat) b++;
      cyc++;
    end
    chk("beat_count", 64'(b), 64'(BEATS));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t r;
    // {ic_req, dc_req, dc_we, ic_addr, dc_addr, exp_dc, gnt_dly, gap, pre_beat, dbase}
    vecs[0]  = '{1, 0, 0, 64'h1000, 64'h0,         0, 2, 0, 0, 64'hA0};
    vecs[1]  = '{0, 1, 1, 64'h0,    64'h8000_0040, 1, 1, 1, 0, 64'h0};
    vecs[2]  = '{1, 1, 0, 64'h2000, 64'h3000,      1, 0, 0, 0, 64'hB0};
    vecs[3]  = '{1, 0, 0, 64'h2000, 64'h3000,      0, 0, 1, 0, 64'hC0};
    vecs[4]  = '{1, 1, 0, 64'h4000, 64'h5000,      1, 0, 0, 0, 64'h10};
    vecs[5]  = '{1, 1, 0, 64'h4000, 64'h5000,      1, 0, 0, 0, 64'h20};
    vecs[6]  = '{1, 1, 0, 64'h4000, 64'h5000,      1, 0, 0, 0, 64'h30};
    vecs[7]  = '{1, 1, 0, 64'h4000, 64'h5000,      0, 0, 0, 0, 64'h40};
    vecs[8]  = '{1, 1, 1, 64'h4000, 64'h5040,      1, 1, 0, 0, 64'h0};
    vecs[9]  = '{1, 0, 0, 64'h4000, 64'h5040,      0, 0, 0, 0, 64'h50};
    vecs[10] = '{0, 1, 0, 64'h0,    64'h7000,      1, 3, 0, 1, 64'h60};

    rst = 1'b0;
    ic_req_i = 0; ic_addr_i = '0; dc_req_i = 0; dc_we_i = 0; dc_addr_i = '0;
    dc_wdata_i = '0; mem_gnt_i = 0; mem_beat_i = 0; mem_rdata_i = '0;
    repeat (2) @(negedge clk);
    #1;
    chk_all_zero();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 11; i++) begin
      ic_req_i  = vecs[i].ic_req;
      dc_req_i  = vecs[i].dc_req;
      dc_we_i   = vecs[i].dc_we;
      ic_addr_i = vecs[i].ic_addr;
      dc_addr_i = vecs[i].dc_addr;
      run_burst(vecs[i], (i == 0) ? 1 : 2);
    end

    // Reset in the middle of a dcache read, two beats in.
    ic_req_i  = 0;
    dc_req_i  = 1;
    dc_we_i   = 0;
    dc_addr_i = 64'h6000;
    wait_req(1'b0, 2);
    chk("rst_pre_addr", mem_addr_o, 64'h6000);
    @(negedge clk);
    mem_gnt_i = 1'b1;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      mem_gnt_i   = 1'b0;
      mem_beat_i  = 1'b1;
      mem_rdata_i = 64'hE0 + 64'(b);
      sb.push_back('{1'b1, 64'hE0 + 64'(b)});
      #1;
      chk("rst_pre_rvalid", dc_rvalid_o, 1);
      sb_check();
    end
    @(negedge clk);
    mem_beat_i  = 1'b1;
    mem_rdata_i = 64'hE2;
    rst         = 1'b0;
    #1;
    chk_all_zero();
    @(negedge clk);
    #1;
    chk("rst_hold_done", dc_done_o | ic_done_o, 0);
    @(negedge clk);
    mem_beat_i = 1'b0;
    rst        = 1'b1;
    r = '{0, 1, 0, 64'h0, 64'h6000, 1, 1, 0, 0, 64'hF0};
    run_burst(r, 1);
    dc_req_i = 0;

    repeat (3) begin
      @(negedge clk);
      mem_beat_i = 1'b0;
      #1;
      chk("idle_no_req", mem_req_o, 0);
    end
    chk("sb_empty", 64'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares the single external memory port between the icache refill path and the dcache refill/writeback path.
- Grants one fixed-length burst at a time and sequences the address and data phases with a beat counter.
- Returns per-beat data and a done pulse to the requester that owns the grant.
- Sits between the two caches and the memory interface.
- The dcache has priority because a pending dcache miss stalls the whole pipeline. A starvation limit still guarantees forward progress for the icache.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, beat data width.
- BEATS, 4, beats per burst (power of two, ≥2).
- STARVE_MAX, 3, consecutive dcache grants allowed while the icache waits.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- ic_req_i  in  1  icache burst read request; held until ic_done_o.
- ic_addr_i  in  ADDR_W  icache burst base address.
- ic_rvalid_o  out  1  read beat valid to icache.
- ic_done_o  out  1  one-cycle pulse on the last icache beat.
- dc_req_i  in  1  dcache burst request; held until dc_done_o.
- dc_we_i  in  1  1 = writeback burst, 0 = refill read.
- dc_addr_i  in  ADDR_W  dcache burst base address.
- dc_wdata_i  in  DATA_W  write beat data for index dc_beat_o.
- dc_beat_o  out  log2(BEATS)  current beat index.
- dc_rvalid_o  out  1  read beat valid to dcache.
- dc_done_o  out  1  one-cycle pulse on the last dcache beat.
- rdata_o  out  DATA_W  read beat data, shared by both caches; qualify with the matching rvalid.
- mem_req_o  out  1  address-phase request.
- mem_we_o  out  1  burst direction.
- mem_addr_o  out  ADDR_W  burst base address.
- mem_gnt_i  in  1  address accepted.
- mem_wdata_o  out  DATA_W  write beat data.
- mem_beat_i  in  1  one beat transferred (read data valid, or write data consumed).
- mem_rdata_i  in  DATA_W  read beat data.

Behaviour:
- State machine: IDLE, ADDR, DATA. Owner register: IC or DC.
- Reset (rst low, asynchronous): state IDLE, beat counter 0, starve counter 0. All outputs 0: mem_req_o, *_rvalid_o, *_done_o, dc_beat_o, mem_addr_o, mem_we_o.

IDLE, arbitration:
- Only dc_req_i asserted → DC.
- Only ic_req_i asserted → IC.
- Both asserted → DC, unless starve counter == STARVE_MAX, in which case IC.
- On a grant, latch owner, address and we (forced 0 for IC), then go to ADDR next cycle.
- Arbitration latency: request seen in IDLE → mem_req_o high the following cycle.

ADDR:
- mem_req_o = 1; mem_addr_o and mem_we_o are driven from the latched registers.
- mem_gnt_i = 1 → go to DATA, beat counter = 0.
- mem_req_o stays high until gnt; the latched values must stay stable.

DATA:
- Each cycle with mem_beat_i = 1 increments the beat counter.
- Read burst: the owner's rvalid_o = mem_beat_i combinationally; rdata_o = mem_rdata_i.
- Write burst: mem_wdata_o = dc_wdata_i; dc_beat_o = beat counter, combinational from the register.
- Beat with counter == BEATS-1: owner's done_o pulses in the same cycle, and state returns to IDLE.
- Back-to-back bursts: at least one IDLE cycle between bursts.

Starve counter:
- Updated at grant time only.
- DC granted while ic_req_i is high → increment, saturating at STARVE_MAX.
- IC granted → clear.
- DC granted with ic_req_i low → clear.

Boundary conditions:
- A requester dropping req mid-burst is illegal; the burst completes regardless.
- mem_beat_i in IDLE or ADDR is ignored.
- The beat counter is log2(BEATS) wide and must not wrap before done.
- An asynchronous reset mid-burst aborts immediately; no done pulse is issued.

Decomposition:
- Shared defines: state encodings ARB_IDLE/ARB_ADDR/ARB_DATA, owner encodings ARB_OWN_IC/ARB_OWN_DC, default BEATS/STARVE_MAX.
- One natural sub-module: arb_prio_starve, the combinational priority pick plus the saturating starve counter register.
- Everything else stays in cache_bus_arbiter.

Test Plan:
- Lone icache read, BEATS=4, gnt after 2 cycles, beats 0xA0..0xA3 → ic_rvalid_o ×4 with matching rdata_o; ic_done_o on the 4th beat; dc_* outputs stay 0.
- Lone dcache write, addr 0x8000_0040 → mem_we_o=1; dc_beat_o steps 0,1,2,3, advancing only on mem_beat_i (gaps inserted); mem_wdata_o tracks dc_wdata_i; one dc_done_o pulse.
- Both requests in the same cycle, starve=0 → DC granted first; IC granted in the next IDLE; starve counter returns to 0.
- Dcache requests continuously while the icache waits, STARVE_MAX=3 → 3 DC bursts, 4th grant goes to IC, then DC resumes.
- Reset asserted in DATA after beat 1 → all outputs 0 immediately, no done pulse; after release, a pending request is re-arbitrated from IDLE.
- mem_beat_i pulsed during ADDR before gnt → ignored; exactly BEATS beats are counted after gnt.
